reg_write_seq: RTL and testbench

//  Write-side sequencer for the CPU1 data registers (A, B, R).

---
 rtl/reg_write_seq.sv | 118 +++++++++++
 tb/tb_reg_write_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | reg_write_seq: single-write sequencer for the A/B/R data registers,    |
// | with one-cycle enable pulse, readback verify and done/err reporting.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module reg_write_seq #(
    parameter int WIDTH = 4,
    parameter int NREG  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_sel_i,
    input  logic [WIDTH-1:0]      req_data_i,
    output logic [NREG-1:0]       en_o,
    output logic [WIDTH-1:0]      data_o,
    input  logic [NREG*WIDTH-1:0] rdbk_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_VERIFY = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [NREG-1:0]  en_q, en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rd_slice;
    logic             sel_ok;

    // Readback slice of the latched target; only consulted when sel_q is legal.
    always_comb begin
        rd_slice = '0;
        for (int k = 0; k < NREG; k++) begin
            if (int'(sel_q) == k) begin
                rd_slice = rdbk_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_ok = int'(req_sel_i) < NREG;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        en_d    = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    sel_d  = req_sel_i;
                    data_d = req_data_i;
                    if (sel_ok) begin
                        state_d = S_WRITE;
                        for (int k = 0; k < NREG; k++) begin
                            en_d[k] = (int'(req_sel_i) == k);
                        end
                    end else begin
                        state_d = S_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_VERIFY;
            end
            S_VERIFY: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                err_d   = (rd_slice != data_q);
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign en_o        = en_q;
    assign data_o      = data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_reg_write_seq: directed bench with a three-register model on the    |
// | write bus and an override hook to corrupt register R's readback.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_reg_write_seq;

    localparam int WIDTH = 4;
    localparam int NREG  = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [1:0]            req_sel = '0;
    logic [WIDTH-1:0]      req_data = '0;
    logic [NREG-1:0]       en;
    logic [WIDTH-1:0]      data;
    logic [NREG*WIDTH-1:0] rdbk;
    logic                  busy, done, err;

    logic [WIDTH-1:0]      regs [NREG];
    logic                  ovr_en = 1'b0;
    logic [WIDTH-1:0]      ovr_val = '0;

    int n_vec = 0;
    int n_err = 0;

    reg_write_seq #(.WIDTH(WIDTH), .NREG(NREG)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_sel_i   (req_sel),
        .req_data_i  (req_data),
        .en_o        (en),
        .data_o      (data),
        .rdbk_i      (rdbk),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        end else begin
            for (int k = 0; k < NREG; k++) if (en[k]) regs[k] <= data;
        end
    end

    always_comb begin
        for (int k = 0; k < NREG; k++) rdbk[k*WIDTH +: WIDTH] = regs[k];
        if (ovr_en) rdbk[2*WIDTH +: WIDTH] = ovr_val;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [WIDTH-1:0] d);
        req_valid = 1'b1;
        req_sel   = sel;
        req_data  = d;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_en", en, 0);
        check("rst_busy", busy, 0);
        tick(); tick();
        rst = 1'b0;
        check("rst_data", data, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", req_ready, 1);

        // 1: simple write to A
        issue(2'd0, 4'hA);
        tick();
        req_valid = 1'b0;
        check("t1_en_n1", en, 3'b001);
        check("t1_data_n1", data, 4'hA);
        check("t1_ready_n1", req_ready, 0);
        check("t1_busy_n1", busy, 1);
        tick();
        check("t1_en_n2", en, 3'b000);
        check("t1_done_n2", done, 0);
        tick();
        check("t1_done_n3", done, 1);
        check("t1_err_n3", err, 0);
        tick();
        check("t1_ready_n4", req_ready, 1);
        check("t1_done_n4", done, 0);
        check("t1_regA", regs[0], 4'hA);

        // 2: readback mismatch on R
        ovr_en  = 1'b1;
        ovr_val = 4'h4;
        issue(2'd2, 4'h5);
        tick();
        req_valid = 1'b0;
        check("t2_en_n1", en, 3'b100);
        check("t2_data_n1", data, 4'h5);
        tick();
        check("t2_en_n2", en, 3'b000);
        tick();
        check("t2_done_n3", done, 1);
        check("t2_err_n3", err, 1);
        check("t2_en_n3", en, 3'b000);
        tick();
        check("t2_err_n4", err, 0);
        check("t2_ready_n4", req_ready, 1);
        ovr_en = 1'b0;

        // 3: illegal select
        issue(2'd3, 4'hF);
        tick();
        req_valid = 1'b0;
        check("t3_en_n1", en, 3'b000);
        check("t3_done_n1", done, 1);
        check("t3_err_n1", err, 1);
        check("t3_ready_n1", req_ready, 0);
        tick();
        check("t3_en_n2", en, 3'b000);
        check("t3_ready_n2", req_ready, 1);
        check("t3_done_n2", done, 0);
        check("t3_err_n2", err, 0);

        // 4: back-to-back with valid held
        issue(2'd1, 4'h3);
        tick();
        check("t4a_en_n1", en, 3'b010);
        check("t4a_data_n1", data, 4'h3);
        issue(2'd0, 4'hC);
        tick();
        check("t4a_en_n2", en, 3'b000);
        check("t4a_data_hold", data, 4'h3);
        tick();
        check("t4a_done_n3", done, 1);
        check("t4a_err_n3", err, 0);
        check("t4a_en_n3", en, 3'b000);
        tick();
        check("t4b_ready_n4", req_ready, 1);
        check("t4b_en_n4", en, 3'b000);
        tick();
        req_valid = 1'b0;
        check("t4b_en_n5", en, 3'b001);
        check("t4b_data_n5", data, 4'hC);
        tick();
        check("t4b_en_n6", en, 3'b000);
        tick();
        check("t4b_done_n7", done, 1);
        check("t4b_err_n7", err, 0);
        tick();
        check("t4b_ready_n8", req_ready, 1);
        check("t4_regB", regs[1], 4'h3);
        check("t4_regA", regs[0], 4'hC);

        // 5: reset during WRITE
        issue(2'd1, 4'h7);
        tick();
        req_valid = 1'b0;
        check("t5_en_write", en, 3'b010);
        #2;
        rst = 1'b1;
        #1;
        check("t5_en_async", en, 3'b000);
        check("t5_busy_async", busy, 0);
        check("t5_done_async", done, 0);
        tick();
        check("t5_done_rst", done, 0);
        check("t5_regB_rst", regs[1], 4'h0);
        rst = 1'b0;
        tick();
        check("t5_ready_post", req_ready, 1);
        issue(2'd2, 4'h9);
        tick();
        req_valid = 1'b0;
        check("t5_en_post", en, 3'b100);
        tick();
        tick();
        check("t5_done_post", done, 1);
        check("t5_err_post", err, 0);
        tick();
        check("t5_regR", regs[2], 4'h9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
